// File: rtl/ifu_fetch.sv
// Instruction fetch unit: reads the current PC, fetches one word over a valid/ready read bus,
// and hands it to decode; a decode accept pulses pc_wen to advance the PC register.
module ifu_fetch #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_wen,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    // state | meaning
    // IDLE  | one cycle after reset before the first fetch
    // AR    | address phase; a misaligned pc skips the bus and faults
    // R     | waiting for read data, bounded by TIMEOUT
    // HOLD  | instruction presented to decode until accepted
    typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            inst     <= '0;
            inst_pc  <= '0;
            inst_err <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= AR;
                AR: begin
                    if (pc[1:0] != 2'b00) begin
                        inst_pc  <= pc;
                        inst     <= '0;
                        inst_err <= 1'b1;
                        state    <= HOLD;
                    end else if (mem_arready) begin
                        inst_pc <= pc;
                        state   <= R;
                    end
                end
                R: begin
                    if (mem_rvalid) begin
                        inst     <= (mem_rresp == 2'b00) ? mem_rdata : '0;
                        inst_err <= (mem_rresp != 2'b00);
                        cnt      <= '0;
                        state    <= HOLD;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // a late response after this point is not supported
                        inst     <= '0;
                        inst_err <= 1'b1;
                        cnt      <= '0;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: if (inst_ready) state <= AR;
                default: state <= IDLE;
            endcase
        end
    end

    // Address phase decodes from the live pc so the PC advanced by pc_wen is used directly.
    assign mem_arvalid = (state == AR) && (pc[1:0] == 2'b00);
    assign mem_araddr  = mem_arvalid ? pc : '0;
    assign mem_rready  = (state == R);
    assign inst_valid  = (state == HOLD);
    assign pc_wen      = inst_valid && inst_ready;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: the tasks run in sequence, each continuing from the DUT state
// the previous one left; the bench advances pc itself whenever it sees pc_wen.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_wen;
    logic        mem_arvalid, mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid, mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        inst_err;

    int checks = 0;
    int errors = 0;
    int pc_wen_cnt = 0;

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_wen(pc_wen),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pc_wen) pc_wen_cnt <= pc_wen_cnt + 1;

    wire [100:0] all_out = {mem_arvalid, mem_araddr, mem_rready, inst_valid,
                            inst, inst_pc, inst_err, pc_wen};

    task test_reset;
        rst = 1'b1; pc = 32'h8000_0000; mem_arready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; mem_rresp = 2'b00; inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 checks++;
        if (all_out !== 101'd0) begin
            errors++; $display("FAIL reset_outputs: got %h exp 0", all_out);
        end
    endtask

    task test_basic;
        @(negedge clk); rst = 1'b0; mem_arready = 1'b1;
        #1 checks++;
        if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL idle_arvalid: got %b exp 0", mem_arvalid); end
        @(negedge clk); #1 checks++;
        if ({mem_arvalid, mem_araddr, mem_rready} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            errors++; $display("FAIL basic_ar: got %b %h %b exp 1 80000000 0", mem_arvalid, mem_araddr, mem_rready);
        end
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
        #1 checks++;
        if ({mem_rready, mem_arvalid, inst_valid} !== 3'b100) begin
            errors++; $display("FAIL basic_r: got %b%b%b exp 100", mem_rready, mem_arvalid, inst_valid);
        end
        @(negedge clk); mem_rvalid = 1'b0;
        #1 checks++;
        if ({inst_valid, inst, inst_pc, inst_err, pc_wen} !== {1'b1, 32'h0000_0413, 32'h8000_0000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL basic_hold: got v=%b inst=%h pc=%h err=%b wen=%b", inst_valid, inst, inst_pc, inst_err, pc_wen);
        end
        @(negedge clk); pc = pc + 32'd4; mem_arready = 1'b0;
        #1 checks++;
        if ({pc_wen_cnt[3:0], mem_arvalid, mem_araddr, inst_valid, pc_wen} !== {4'd1, 1'b1, 32'h8000_0004, 1'b0, 1'b0}) begin
            errors++; $display("FAIL basic_next_ar: got cnt=%0d arv=%b addr=%h v=%b wen=%b", pc_wen_cnt, mem_arvalid, mem_araddr, inst_valid, pc_wen);
        end
    endtask

    task test_ar_stall;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            #1 checks++;
            if ({mem_arvalid, mem_araddr, mem_rready, pc_wen} !== {1'b1, 32'h8000_0004, 1'b0, 1'b0}) begin
                errors++; $display("FAIL ar_stall_%0d: got arv=%b addr=%h rr=%b wen=%b", i, mem_arvalid, mem_araddr, mem_rready, pc_wen);
            end
            @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_arready = 1'b1;
        #1 checks++;
        if ({mem_arvalid, pc_wen_cnt[3:0]} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL ar_stall_release: got arv=%b cnt=%0d exp 1 1", mem_arvalid, pc_wen_cnt);
        end
        @(negedge clk);
    endtask

    task test_hold_stall;
        mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0093; mem_arready = 1'b0; inst_ready = 1'b0;
        #1 checks++;
        if (mem_rready !== 1'b1) begin errors++; $display("FAIL hold_stall_r: got %b exp 1", mem_rready); end
        @(negedge clk); mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 checks++;
            if ({inst_valid, inst, inst_pc, pc_wen, mem_arvalid} !== {1'b1, 32'h00A0_0093, 32'h8000_0004, 1'b0, 1'b0}) begin
                errors++; $display("FAIL hold_stall_%0d: got v=%b inst=%h pc=%h wen=%b arv=%b", i, inst_valid, inst, inst_pc, pc_wen, mem_arvalid);
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
        #1 checks++;
        if ({inst_valid, pc_wen} !== 2'b11) begin errors++; $display("FAIL hold_accept: got %b%b exp 11", inst_valid, pc_wen); end
        @(negedge clk); pc = pc + 32'd4;
        #1 checks++;
        if ({pc_wen_cnt[3:0], mem_arvalid, mem_araddr} !== {4'd2, 1'b1, 32'h8000_0008}) begin
            errors++; $display("FAIL hold_next_ar: got cnt=%0d arv=%b addr=%h", pc_wen_cnt, mem_arvalid, mem_araddr);
        end
    endtask

    task test_misaligned;
        mem_arready = 1'b1;
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk); mem_rvalid = 1'b0;
        #1 checks++;
        if (pc_wen !== 1'b1) begin errors++; $display("FAIL mis_prev_accept: got %b exp 1", pc_wen); end
        @(negedge clk); pc = 32'h8000_0002;
        #1 checks++;
        if ({mem_arvalid, mem_araddr, inst_valid} !== {1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL mis_no_ar: got arv=%b addr=%h v=%b", mem_arvalid, mem_araddr, inst_valid);
        end
        @(negedge clk); #1 checks++;
        if ({inst_valid, inst_err, inst, inst_pc, mem_arvalid} !== {1'b1, 1'b1, 32'h0, 32'h8000_0002, 1'b0}) begin
            errors++; $display("FAIL mis_hold: got v=%b err=%b inst=%h pc=%h arv=%b", inst_valid, inst_err, inst, inst_pc, mem_arvalid);
        end
        @(negedge clk); pc = 32'h8000_0010;
    endtask

    task test_rresp;
        #1 checks++;
        if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h8000_0010}) begin
            errors++; $display("FAIL rresp_ar: got %b %h exp 1 80000010", mem_arvalid, mem_araddr);
        end
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_rresp = 2'd2;
        @(negedge clk); mem_rvalid = 1'b0; mem_rresp = 2'd0;
        #1 checks++;
        if ({inst_valid, inst_err, inst, inst_pc} !== {1'b1, 1'b1, 32'h0, 32'h8000_0010}) begin
            errors++; $display("FAIL rresp_err: got v=%b err=%b inst=%h pc=%h", inst_valid, inst_err, inst, inst_pc);
        end
        @(negedge clk); pc = 32'h8000_0014;
    endtask

    task test_timeout;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 checks++;
            if ({mem_rready, inst_valid} !== 2'b10) begin
                errors++; $display("FAIL timeout_r%0d: got rr=%b v=%b exp 1 0", i, mem_rready, inst_valid);
            end
            @(negedge clk);
        end
        #1 checks++;
        if ({inst_valid, inst_err, inst, inst_pc, mem_rready} !== {1'b1, 1'b1, 32'h0, 32'h8000_0014, 1'b0}) begin
            errors++; $display("FAIL timeout_hold: got v=%b err=%b inst=%h pc=%h rr=%b", inst_valid, inst_err, inst, inst_pc, mem_rready);
        end
        @(negedge clk); pc = 32'h8000_0018;
    endtask

    task test_reset_in_r;
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234; rst = 1'b1;
        #1 checks++;
        if (mem_rready !== 1'b1) begin errors++; $display("FAIL rst_r_state: got %b exp 1", mem_rready); end
        @(negedge clk); rst = 1'b0; mem_rvalid = 1'b0;
        #1 checks++;
        if (all_out !== 101'd0) begin errors++; $display("FAIL rst_in_r_outputs: got %h exp 0", all_out); end
        @(negedge clk); #1 checks++;
        if ({mem_arvalid, mem_araddr} !== {1'b1, 32'h8000_0018}) begin
            errors++; $display("FAIL rst_resume_ar: got %b %h exp 1 80000018", mem_arvalid, mem_araddr);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'h0000_5678;
        @(negedge clk); mem_rvalid = 1'b0;
        #1 checks++;
        if ({inst_valid, inst_err, inst, inst_pc, pc_wen} !== {1'b1, 1'b0, 32'h0000_5678, 32'h8000_0018, 1'b1}) begin
            errors++; $display("FAIL rst_resume_hold: got v=%b err=%b inst=%h pc=%h wen=%b", inst_valid, inst_err, inst, inst_pc, pc_wen);
        end
        @(negedge clk); #1 checks++;
        if (pc_wen_cnt !== 7) begin errors++; $display("FAIL pc_wen_total: got %0d exp 7", pc_wen_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ar_stall;
        test_hold_stall;
        test_misaligned;
        test_rresp;
        test_timeout;
        test_reset_in_r;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

endmodule
